alu_input_sequencer: RTL
========================

// Module: alu_input_sequencer
// PURPOSE
//  Micro-sequencer for the ALU operand path. On a start request it drives the A-side input
//  register loads (zero_add, sb_add), the B-side loads (db_add, ndb_add), the ALU
//  function select and carry-in, then the result-to-special-bus strobe (add_sb).
//  Sits between the instruction decode/timing logic and the ALU/input-register datapath.
// PARAMETERS
//  LOAD_CYCLES  1  cycles the operand load lines stay asserted; legal range 1..4
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  start         in   1  request a new ALU operation; sampled only in IDLE
//  op            in   3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 EOR, 5 SHR, 6 INC, 7 PASS
//  carry_flag    in   1  processor C flag; used as carry-in for ADD/SUB
//  decimal_flag  in   1  processor D flag; used only with DECIMAL_MODE_EN
//  busy          out  1  high from the cycle after accept through the WB cycle
//  done          out  1  one-cycle pulse in the WB cycle
//  zero_add      out  1  A-side load: zeros
//  sb_add        out  1  A-side load: special bus
//  db_add        out  1  B-side load: data bus
//  ndb_add       out  1  B-side load: inverted data bus
//  sums,ands,ors,eors,srs  out 1 each  ALU function select; one-hot
//  i_addc        out  1  ALU carry-in
//  add_sb        out  1  drive ALU result onto the special bus
//  daa, dsa      out  1  decimal add/subtract correction enables
// BEHAVIOUR
//  - All outputs are registered. Reset forces state IDLE and every output to 0 on the next edge.
//  - States: IDLE -> LOAD -> EXEC -> [CORR] -> WB -> IDLE.
//  - IDLE: start=1 at an edge latches op, carry_flag and decimal_flag and moves to LOAD.
//    start is ignored in every other state; the latched values are frozen until IDLE.
//  - LOAD: lasts LOAD_CYCLES cycles, counted by a down-counter. Exactly one A-side load and
//    one B-side load are asserted:
//      ADD: sb_add+db_add    SUB: sb_add+ndb_add   AND/OR/EOR: sb_add+db_add
//      SHR: zero_add+db_add  INC: zero_add+db_add  PASS: zero_add+db_add
//  - EXEC: 1 cycle. Load lines are 0. One function select is high (ADD/SUB/INC/PASS: sums;
//    AND: ands; OR: ors; EOR: eors; SHR: srs). i_addc = latched carry for ADD/SUB, 1 for INC,
//    0 otherwise.
//  - WB: 1 cycle. add_sb=1 and done=1; every other control is 0. Next state is IDLE.
//  - busy = LOAD_CYCLES+2 cycles per op (+1 with CORR). Start after done: earliest
//    accept is the IDLE cycle that follows WB. There is no back-to-back accept.
//  - Invariants checked every cycle: at most one A-side load is high, at most one B-side
//    load is high, and at most one function select is high. add_sb is never high in the
//    same cycle as any load line.
//  - Reset during any state aborts the operation. No done is produced for it.
//  - A LOAD_CYCLES value outside 1..4 is clamped to the nearest legal value.
// CONFIGURATION
//  DECIMAL_MODE_EN defined: if the latched decimal_flag=1 and op is ADD or SUB, a CORR cycle
//    is inserted after EXEC. In it daa=1 (ADD) or dsa=1 (SUB), and sums stays high.
//  DECIMAL_MODE_EN undefined: no CORR state exists. daa and dsa are tied to 0, and
//    decimal_flag is ignored.
// TESTING
//  1. reset=1 mid-LOAD -> next cycle all outputs 0 and busy=0; start one cycle later accepted.
//  2. LOAD_CYCLES=1, op=ADD, carry_flag=1, start pulse at T -> T+1: sb_add,db_add;
//     T+2: sums,i_addc; T+3: add_sb,done; T+4: busy=0.
//  3. LOAD_CYCLES=3, op=SHR -> zero_add+db_add high for 3 cycles, then srs for 1 cycle with
//     i_addc=0, then done. busy is high for 5 cycles.
//  4. op=INC with carry_flag=0 -> i_addc=1 in EXEC. op=SUB -> ndb_add high and db_add low in LOAD.
//  5. start held high continuously -> one accept every LOAD_CYCLES+3 cycles. op changes
//     while busy have no effect on the running operation.
//  6. DECIMAL_MODE_EN defined, decimal_flag=1, op=SUB -> CORR cycle with dsa=1 between EXEC
//     and WB. Same stimulus without the macro -> no CORR cycle, dsa stays 0.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: ALU operand-path micro-sequencer, LOAD -> EXEC -> [CORR] -> WB (CORR only with DECIMAL_MODE_EN).
module alu_input_sequencer #(
  parameter int LOAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       carry_flag,
  input  logic       decimal_flag,
  output logic       busy,
  output logic       done,
  output logic       zero_add,
  output logic       sb_add,
  output logic       db_add,
  output logic       ndb_add,
  output logic       sums,
  output logic       ands,
  output logic       ors,
  output logic       eors,
  output logic       srs,
  output logic       i_addc,
  output logic       add_sb,
  output logic       daa,
  output logic       dsa
);
  localparam int LC = LOAD_CYCLES < 1 ? 1 : (LOAD_CYCLES > 4 ? 4 : LOAD_CYCLES);
  typedef struct packed {
    logic busy, done, zero_add, sb_add, db_add, ndb_add;
    logic sums, ands, ors, eors, srs, i_addc, add_sb, daa, dsa;
  } ctl_t;
`ifdef DECIMAL_MODE_EN
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CORR, WB} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB} state_t;
`endif
  state_t     state_q;
  ctl_t       ctl_q;
  logic [1:0] cnt_q;
  logic [2:0] op_q;
  logic       c_q;
  function automatic ctl_t load_ctl(input logic [2:0] o);
    ctl_t c = '0;
    c.busy     = 1'b1;
    c.zero_add = o inside {3'd5, 3'd6, 3'd7};
    c.sb_add   = !c.zero_add;
    c.ndb_add  = o == 3'd1;
    c.db_add   = !c.ndb_add;
    return c;
  endfunction
  function automatic ctl_t exec_ctl(input logic [2:0] o, input logic cin);
    ctl_t c = '0;
    c.busy   = 1'b1;
    c.sums   = o inside {3'd0, 3'd1, 3'd6, 3'd7};
    c.ands   = o == 3'd2;
    c.ors    = o == 3'd3;
    c.eors   = o == 3'd4;
    c.srs    = o == 3'd5;
    c.i_addc = o[2:1] == 2'd0 ? cin : o == 3'd6;
    return c;
  endfunction
  function automatic ctl_t wb_ctl();
    ctl_t c = '0;
    c.busy   = 1'b1;
    c.done   = 1'b1;
    c.add_sb = 1'b1;
    return c;
  endfunction
`ifdef DECIMAL_MODE_EN
  logic d_q;
  function automatic ctl_t corr_ctl(input logic [2:0] o);
    ctl_t c = '0;
    c.busy = 1'b1;
    c.sums = 1'b1;
    c.daa  = o == 3'd0;
    c.dsa  = o == 3'd1;
    return c;
  endfunction
  always_ff @(posedge clk)
    if (reset) d_q <= 1'b0;
    else if (state_q == IDLE && start) d_q <= decimal_flag;
`else
  logic unused_decimal;
  assign unused_decimal = decimal_flag;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          ctl_q   <= load_ctl(op);
          cnt_q   <= 2'(LC - 1);
          op_q    <= op;
          c_q     <= carry_flag;
        end else ctl_q <= '0;
        LOAD: if (cnt_q == 2'd0) begin
          state_q <= EXEC;
          ctl_q   <= exec_ctl(op_q, c_q);
        end else cnt_q <= cnt_q - 2'd1;
`ifdef DECIMAL_MODE_EN
        EXEC: if (d_q && op_q[2:1] == 2'd0) begin
          state_q <= CORR;
          ctl_q   <= corr_ctl(op_q);
        end else begin
          state_q <= WB;
          ctl_q   <= wb_ctl();
        end
        CORR: begin
          state_q <= WB;
          ctl_q   <= wb_ctl();
        end
`else
        EXEC: begin
          state_q <= WB;
          ctl_q   <= wb_ctl();
        end
`endif
        default: begin
          state_q <= IDLE;
          ctl_q   <= '0;
        end
      endcase
    end
  end
  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign zero_add = ctl_q.zero_add;
  assign sb_add   = ctl_q.sb_add;
  assign db_add   = ctl_q.db_add;
  assign ndb_add  = ctl_q.ndb_add;
  assign sums     = ctl_q.sums;
  assign ands     = ctl_q.ands;
  assign ors      = ctl_q.ors;
  assign eors     = ctl_q.eors;
  assign srs      = ctl_q.srs;
  assign i_addc   = ctl_q.i_addc;
  assign add_sb   = ctl_q.add_sb;
  assign daa      = ctl_q.daa;
  assign dsa      = ctl_q.dsa;
endmodule
